// File: rtl/mult_pkg.sv
// Shared types and width helpers for the iterative carry-save multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int PROD_W(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/carry_save_adder_y_equal_z.sv
// One carry-save stage: three operands in, redundant sum/carry out with the carry pre-shifted.
module carry_save_adder_y_equal_z #(
    parameter int DATA_SIZE_x = 16,
    parameter int DATA_SIZE_y = 16
) (
    input  logic [DATA_SIZE_x-1:0] x,
    input  logic [DATA_SIZE_y-1:0] y,
    input  logic [DATA_SIZE_y-1:0] z,
    output logic [DATA_SIZE_y-1:0] u,
    output logic [DATA_SIZE_y:0]   v
);

    logic [DATA_SIZE_y-1:0] xe;

    // x may be narrower than y/z; it is zero-extended to the common width.
    assign xe = DATA_SIZE_y'(x);
    assign u  = xe ^ y ^ z;
    assign v  = {(xe & y) | (xe & z) | (y & z), 1'b0};

endmodule

// File: rtl/csa_mult_sequencer.sv
// Radix-2 unsigned multiplier: one partial product per cycle into carry-save
// sum/carry registers, then a single carry-propagate resolve cycle.
//
// state   | meaning
// IDLE    | waiting for an operand pair, in_ready_o high
// ACCUM   | adding one partial product per edge in redundant form
// RESOLVE | collapsing sum + carry into product_o
// DONE    | product_o valid, held until out_ready_i
module csa_mult_sequencer
    import mult_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_SIZE-1:0]     a_i,
    input  logic [DATA_SIZE-1:0]     b_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [2*DATA_SIZE-1:0]   product_o,
    output logic                     busy_o
);

    localparam int PW = PROD_W(DATA_SIZE);
    localparam int CW = clog2(DATA_SIZE) + 1;

    state_t                state;
    logic [PW-1:0]         s_q;
    logic [PW-1:0]         c_q;
    logic [PW-1:0]         a_q;
    logic [DATA_SIZE-1:0]  b_q;
    logic [CW-1:0]         count;

    logic [PW-1:0]         pp;
    logic [PW-1:0]         s_next;
    logic [PW:0]           v_next;
    logic                  last_accum;

    assign pp = b_q[0] ? a_q : '0;

    // With early exit, stop once no set multiplier bits remain after this one.
    assign last_accum = (count == CW'(DATA_SIZE - 1)) ||
                        (EARLY_EXIT && ((b_q >> 1) == '0));

    carry_save_adder_y_equal_z #(
        .DATA_SIZE_x (PW),
        .DATA_SIZE_y (PW)
    ) u_csa (
        .x (pp),
        .y (s_q),
        .z (c_q),
        .u (s_next),
        .v (v_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            count       <= '0;
            product_o   <= '0;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q        <= PW'(a_i);
                        b_q        <= b_i;
                        s_q        <= '0;
                        c_q        <= '0;
                        count      <= '0;
                        state      <= ACCUM;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                ACCUM: begin
                    s_q   <= s_next;
                    // The carry out of the top bit is dropped; the product fits in PW bits.
                    c_q   <= v_next[PW-1:0];
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    count <= count + CW'(1);
                    if (last_accum) begin
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    product_o   <= s_q + c_q;
                    out_valid_o <= 1'b1;
                    busy_o      <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    in_ready_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Bench for csa_mult_sequencer: three instances (N=8, N=8 early exit, N=16)
// checked against plain a*b and a latency rule derived from the multiplier's bits.
module tb_csa_mult_sequencer;

    logic        clk;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  busy;
    logic [15:0] a [3];
    logic [15:0] b [3];
    logic [15:0] p0;
    logic [15:0] p1;
    logic [31:0] p2;

    int total;
    int bad;
    int in_hs  [3];
    int out_hs [3];
    int n_txn  [3];
    int n_abort[3];

    csa_mult_sequencer #(.DATA_SIZE(8), .EARLY_EXIT(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .a_i(a[0][7:0]), .b_i(b[0][7:0]), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]), .product_o(p0), .busy_o(busy[0]));

    csa_mult_sequencer #(.DATA_SIZE(8), .EARLY_EXIT(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .a_i(a[1][7:0]), .b_i(b[1][7:0]), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]), .product_o(p1), .busy_o(busy[1]));

    csa_mult_sequencer #(.DATA_SIZE(16), .EARLY_EXIT(1'b0)) dut2 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .a_i(a[2]), .b_i(b[2]), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready[2]), .product_o(p2), .busy_o(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && in_valid[i] && in_ready[i])   in_hs[i]  <= in_hs[i] + 1;
            if (!rst && out_valid[i] && out_ready[i]) out_hs[i] <= out_hs[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] prod(input int idx);
        if (idx == 0) return {16'b0, p0};
        if (idx == 1) return {16'b0, p1};
        return p2;
    endfunction

    function automatic int width_of(input int idx);
        return (idx == 2) ? 16 : 8;
    endfunction

    // Edges from accept to out_valid: N accumulations (or up to the top set bit) plus resolve.
    function automatic int exp_lat(input int idx, input logic [15:0] bv);
        int k;
        if (idx != 1) return width_of(idx) + 1;
        k = 0;
        for (int i = 0; i < 8; i++) if (bv[i]) k = i + 1;
        if (k < 1) k = 1;
        return k + 1;
    endfunction

    task automatic run_txn(input int idx, input logic [15:0] av_in, input logic [15:0] bv_in,
                           input int stall);
        logic [15:0] mask;
        logic [15:0] av;
        logic [15:0] bv;
        logic [31:0] expv;
        int          cyc;
        int          busy_cyc;
        int          lat;
        mask = (idx == 2) ? 16'hFFFF : 16'h00FF;
        av   = av_in & mask;
        bv   = bv_in & mask;
        expv = 32'(av) * 32'(bv);
        lat  = exp_lat(idx, bv);
        chk($sformatf("in_ready_idle%0d", idx), 64'(in_ready[idx]), 64'd1);
        in_valid[idx] = 1'b1;
        a[idx] = av;
        b[idx] = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        a[idx] = 16'($urandom);
        b[idx] = 16'($urandom);
        cyc = 0;
        busy_cyc = 0;
        while (!out_valid[idx] && cyc < 200) begin
            if (busy[idx]) busy_cyc++;
            chk($sformatf("in_ready_busy%0d", idx), 64'(in_ready[idx]), 64'd0);
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("latency%0d", idx), 64'(cyc), 64'(lat));
        chk($sformatf("busy_cycles%0d", idx), 64'(busy_cyc), 64'(lat));
        chk($sformatf("product%0d", idx), 64'(prod(idx)), 64'(expv));
        chk($sformatf("busy_done%0d", idx), 64'(busy[idx]), 64'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid[idx] = 1'b1;
            a[idx] = 16'($urandom);
            b[idx] = 16'($urandom);
            @(negedge clk);
            chk($sformatf("stall_product%0d", idx), 64'(prod(idx)), 64'(expv));
            chk($sformatf("stall_valid%0d", idx), 64'(out_valid[idx]), 64'd1);
            chk($sformatf("stall_in_ready%0d", idx), 64'(in_ready[idx]), 64'd0);
        end
        in_valid[idx] = 1'b0;
        out_ready[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[idx] = 1'b0;
        chk($sformatf("drain_valid%0d", idx), 64'(out_valid[idx]), 64'd0);
        chk($sformatf("drain_in_ready%0d", idx), 64'(in_ready[idx]), 64'd1);
        chk($sformatf("drain_product%0d", idx), 64'(prod(idx)), 64'(expv));
        n_txn[idx]++;
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            in_hs[i] = 0; out_hs[i] = 0; n_txn[i] = 0; n_abort[i] = 0;
            a[i] = '0; b[i] = '0;
        end
        in_valid = '0;
        out_ready = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
            chk($sformatf("rst_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
            chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
            chk($sformatf("rst_product%0d", i), 64'(prod(i)), 64'd0);
        end

        run_txn(0, 16'h00FF, 16'h00FF, 0);
        run_txn(0, 16'h0000, 16'h00A5, 1);
        run_txn(0, 16'h0037, 16'h0000, 0);
        run_txn(1, 16'h0037, 16'h0000, 0);
        run_txn(1, 16'h000D, 16'h0003, 0);
        run_txn(1, 16'h000D, 16'h0080, 0);
        run_txn(0, 16'h00FF, 16'h00FF, 5);

        // Reset lands on the 4th accumulate edge of dut0.
        chk("abort_in_ready", 64'(in_ready[0]), 64'd1);
        in_valid[0] = 1'b1;
        a[0] = 16'h0012;
        b[0] = 16'h0034;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_abort[0]++;
        chk("abort_out_valid", 64'(out_valid[0]), 64'd0);
        chk("abort_product", 64'(p0), 64'd0);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_in_ready_after", 64'(in_ready[0]), 64'd1);
        repeat (3) @(negedge clk);
        chk("abort_no_output", 64'(out_valid[0]), 64'd0);
        run_txn(0, 16'h0012, 16'h0034, 0);

        fork
            begin
                for (int t = 0; t < 350; t++)
                    run_txn(0, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
            end
            begin
                for (int t = 0; t < 350; t++)
                    run_txn(1, 16'($urandom), 16'($urandom_range(0, 255) >> $urandom_range(0, 7)),
                            int'($urandom_range(0, 3)));
            end
            begin
                for (int t = 0; t < 350; t++)
                    run_txn(2, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
            end
        join

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("in_handshakes%0d", i), 64'(in_hs[i]), 64'(n_txn[i] + n_abort[i]));
            chk($sformatf("out_handshakes%0d", i), 64'(out_hs[i]), 64'(n_txn[i]));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_mult_sequencer.md
Name: csa_mult_sequencer

Overview:
- Iterative radix-2 unsigned multiplier controller built around a 2N-bit carry-save adder datapath.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Accumulates one partial product per cycle in redundant form (sum and carry registers), then performs one carry-propagate resolve cycle.
- Sits between the configurable multiplier's operand front end and its result consumer; provides the sequential, low-area alternative to the combinational array.

Parameters:
DATA_SIZE, 8, operand width N (>= 2); product width is 2N.
EARLY_EXIT, 0, 1 = leave ACCUM as soon as the remaining multiplier bits are all zero.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset; synchronous, active-high.
in_valid_i  in  1  operand pair valid.
in_ready_o  out  1  sequencer can accept operands; high only in IDLE.
a_i  in  N  multiplicand, unsigned.
b_i  in  N  multiplier, unsigned.
out_valid_o  out  1  product_o valid; held until accepted.
out_ready_i  in  1  consumer accepts product.
product_o  out  2N  a*b, unsigned.
busy_o  out  1  high in ACCUM or RESOLVE.

Behaviour:
- Reset (rst_i sampled high on an edge):
  - state=IDLE; S, C, A, B, count and product_o cleared to 0.
  - out_valid_o=0, busy_o=0, in_ready_o=1 after that edge.
  - Reset mid-transaction discards all work; no output is produced.
- FSM states: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - in_ready_o=1.
  - On an edge with in_valid_i=1: latch A=zero-extended a_i (2N bits) and B=b_i; S=0, C=0, count=0; go to ACCUM.
- ACCUM, each edge:
  - Partial product PP = B[0] ? A : 0.
  - S <= S ^ C ^ PP.
  - C <= (majority(S,C,PP) << 1), truncated to 2N bits. Dropping the MSB is exact modulo 2^2N because the product never exceeds 2N bits.
  - A <= A << 1; B <= B >> 1; count <= count + 1.
  - Exit to RESOLVE when count == N-1 on this edge. With EARLY_EXIT=1, also exit when (B>>1)==0.
  - At least one ACCUM cycle always occurs, including b=0.
- RESOLVE, one edge:
  - product_o <= S + C, truncated to 2N bits.
  - out_valid_o <= 1; go to DONE.
- DONE:
  - out_valid_o=1; product_o stable.
  - On an edge with out_ready_i=1: out_valid_o <= 0; go to IDLE.
  - No new operands are accepted in the same cycle; in_ready_o rises only after returning to IDLE.
- Latency, with the handshake accepted on edge T:
  - EARLY_EXIT=0: out_valid_o is high after edge T+N+1.
  - EARLY_EXIT=1: out_valid_o is high after edge T+k+1, where k = max(1, index of highest set bit of b + 1).
- Throughput: one transaction per N+3 cycles minimum with EARLY_EXIT=0 (accept, N accum, resolve, drain). out_ready_i may be held high.
- Input conditions:
  - in_valid_i while not in IDLE is ignored; no latch occurs.
  - a_i and b_i are don't-care outside the accepting edge.
- busy_o = (state==ACCUM) || (state==RESOLVE).
- count width: clog2(N)+1.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE=2'd0, ACCUM=2'd1, RESOLVE=2'd2, DONE=2'd3);
  - clog2 helper function;
  - product-width constant function PROD_W(N)=2N.
- One natural sub-module: the existing carry_save_adder_y_equal_z.
  - Instantiate with DATA_SIZE_x=DATA_SIZE_y=2N.
  - Connections: x=PP, y=S, z=C.
  - Take u as next S and v[2N-1:0] as next C; v[0]=0 supplies the shift.
- The final S+C is a plain behavioural add inside the sequencer.

Test Plan:
- N=8, EARLY_EXIT=0: a=0xFF, b=0xFF accepted at edge T -> out_valid_o high after edge T+9, product_o=0xFE01, busy_o high for exactly 9 cycles.
- N=8: a=0x00, b=0xA5 and a=0x37, b=0x00 -> product_o=0x0000 in both. EARLY_EXIT=1 with b=0x00 -> out_valid_o after T+2.
- N=8, EARLY_EXIT=1: a=0x0D, b=0x03 -> product_o=0x0027, out_valid_o after edge T+3. Then b=0x80 -> full 8 accum cycles, product_o=0x0680.
- Back-pressure: out_ready_i=0 for 5 cycles after out_valid_o -> product_o and out_valid_o stable, in_ready_o=0, new in_valid_i ignored. out_ready_i=1 -> IDLE next edge, in_ready_o=1.
- Reset mid-operation: assert rst_i on the 4th ACCUM edge of a=0x12, b=0x34 -> next cycle state IDLE, out_valid_o=0, product_o=0. A fresh a=0x12, b=0x34 then yields 0x03A8.
- Random: 1000 random pairs with random out_ready_i stalls, N=8 and N=16 -> every product equals a*b, and exactly one output handshake per input handshake.
